// File: rtl/bram_pkg.sv
// Shared definitions for the dual-port clearable block RAM.
//   state_e : controller state (CLEAR sweep / IDLE accepting accesses)
package bram_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

endpackage

// File: rtl/bram_sdp_core.sv
// Storage array: one write/read port (A) and one read-only port (B).
// No reset and registered reads, so synthesis maps it onto block RAM.
//   clk             : clock
//   a_we/a_addr/a_din : port A write
//   a_re/a_rdata    : port A read (latency 1, holds when a_re low)
//   b_re/b_addr/b_rdata : port B read (latency 1, always read-first)
module bram_sdp_core #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 8,
    parameter int WRITE_FIRST = 0
) (
    input  logic                  clk,
    input  logic                  a_we,
    input  logic                  a_re,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_re,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0] b_rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_din;
        end
        // The array read below samples the pre-write contents, giving read-first;
        // write-first bypasses the incoming word instead.
        if (a_re) begin
            a_rdata <= ((WRITE_FIRST != 0) && a_we) ? a_din : mem[a_addr];
        end
        if (b_re) begin
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/bram_dp_clr.sv
// Dual-port block RAM with a hardware clear sweep.
// After reset, and on clear_req, every word is written to zero one address per
// cycle; accesses are refused (ready low) during the sweep.
//   clk, rst_n          : clock, async active-low reset
//   clear_req           : request a full zeroing sweep
//   ready               : idle and accepting accesses
//   a_we/a_re/a_addr/a_din -> a_dout/a_rvalid : port A read/write
//   b_re/b_addr         -> b_dout/b_rvalid    : port B read
//
// state | meaning
// CLEAR | sweeping zeros through the array, accesses ignored
// IDLE  | normal operation
module bram_dp_clr
    import bram_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 8,
    parameter int OUT_REG     = 0,
    parameter int WRITE_FIRST = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_req,
    output logic                  ready,
    input  logic                  a_we,
    input  logic                  a_re,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic [DATA_WIDTH-1:0] a_dout,
    output logic                  a_rvalid,
    input  logic                  b_re,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0] b_dout,
    output logic                  b_rvalid
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                // Leave at the last address instead of letting the counter wrap.
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    logic sweep;
    logic a_we_acc, a_re_acc, b_re_acc;

    assign ready    = (state_q == IDLE);
    assign sweep    = (state_q == CLEAR);
    assign a_we_acc = a_we & ready;
    assign a_re_acc = a_re & ready;
    assign b_re_acc = b_re & ready;

    logic [DATA_WIDTH-1:0] core_a_rdata, core_b_rdata;

    // Port A is borrowed by the sweep while clearing; user traffic is gated off then.
    bram_sdp_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .WRITE_FIRST(WRITE_FIRST)
    ) u_core (
        .clk    (clk),
        .a_we   (sweep | a_we_acc),
        .a_re   (a_re_acc),
        .a_addr (sweep ? cnt_q : a_addr),
        .a_din  (sweep ? '0 : a_din),
        .a_rdata(core_a_rdata),
        .b_re   (b_re_acc),
        .b_addr (b_addr),
        .b_rdata(core_b_rdata)
    );

    logic a_v1_q, b_v1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_v1_q <= 1'b0;
            b_v1_q <= 1'b0;
        end else begin
            a_v1_q <= a_re_acc;
            b_v1_q <= b_re_acc;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  a_v2_q, b_v2_q;
            logic [DATA_WIDTH-1:0] a_dout_q, b_dout_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_v2_q   <= 1'b0;
                    b_v2_q   <= 1'b0;
                    a_dout_q <= '0;
                    b_dout_q <= '0;
                end else begin
                    a_v2_q <= a_v1_q;
                    b_v2_q <= b_v1_q;
                    if (a_v1_q) a_dout_q <= core_a_rdata;
                    if (b_v1_q) b_dout_q <= core_b_rdata;
                end
            end

            assign a_dout   = a_dout_q;
            assign b_dout   = b_dout_q;
            assign a_rvalid = a_v2_q;
            assign b_rvalid = b_v2_q;
        end else begin : g_no_out_reg
            // The RAM read register cannot be reset, so its output is masked to
            // zero until a read has landed since the last reset. It already
            // holds its value between reads.
            logic a_seen_q, b_seen_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_seen_q <= 1'b0;
                    b_seen_q <= 1'b0;
                end else begin
                    a_seen_q <= a_seen_q | a_re_acc;
                    b_seen_q <= b_seen_q | b_re_acc;
                end
            end

            assign a_dout   = a_seen_q ? core_a_rdata : '0;
            assign b_dout   = b_seen_q ? core_b_rdata : '0;
            assign a_rvalid = a_v1_q;
            assign b_rvalid = b_v1_q;
        end
    endgenerate

endmodule

// File: tb/tb_bram_dp_clr.sv
module tb_bram_dp_clr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clear_req = 1'b0;
    logic       a_we = 1'b0, a_re = 1'b0, b_re = 1'b0;
    logic [3:0] a_addr = '0, b_addr = '0;
    logic [7:0] a_din = '0;

    logic       u0_ready, u0_a_rvalid, u0_b_rvalid;
    logic [7:0] u0_a_dout, u0_b_dout;
    logic       u1_ready, u1_a_rvalid, u1_b_rvalid;
    logic [7:0] u1_a_dout, u1_b_dout;

    int compared = 0;
    int mismatched = 0;
    logic [7:0] mem_m [16];

    always #5 clk = ~clk;

    // u0: latency 1, read-first.  u1: latency 2, write-first.
    bram_dp_clr #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .OUT_REG(0), .WRITE_FIRST(0)) u0 (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(u0_ready),
        .a_we(a_we), .a_re(a_re), .a_addr(a_addr), .a_din(a_din),
        .a_dout(u0_a_dout), .a_rvalid(u0_a_rvalid),
        .b_re(b_re), .b_addr(b_addr), .b_dout(u0_b_dout), .b_rvalid(u0_b_rvalid)
    );

    bram_dp_clr #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .OUT_REG(1), .WRITE_FIRST(1)) u1 (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(u1_ready),
        .a_we(a_we), .a_re(a_re), .a_addr(a_addr), .a_din(a_din),
        .a_dout(u1_a_dout), .a_rvalid(u1_a_rvalid),
        .b_re(b_re), .b_addr(b_addr), .b_dout(u1_b_dout), .b_rvalid(u1_b_rvalid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int addr, input logic [7:0] data);
        a_we = 1'b1; a_addr = addr[3:0]; a_din = data;
        tick();
        a_we = 1'b0;
        mem_m[addr] = data;
    endtask

    // Streams reads of 0..15 on both ports and checks order and latency.
    task automatic read_all(input string tag);
        for (int i = 0; i < 18; i++) begin
            a_re = (i < 16); b_re = (i < 16);
            a_addr = i[3:0]; b_addr = i[3:0];
            tick();
            chk({tag, "_u0_av"}, u0_a_rvalid, (i < 16));
            chk({tag, "_u0_bv"}, u0_b_rvalid, (i < 16));
            if (i < 16) begin
                chk({tag, "_u0_ad"}, u0_a_dout, mem_m[i]);
                chk({tag, "_u0_bd"}, u0_b_dout, mem_m[i]);
            end
            chk({tag, "_u1_av"}, u1_a_rvalid, (i >= 1 && i <= 16));
            chk({tag, "_u1_bv"}, u1_b_rvalid, (i >= 1 && i <= 16));
            if (i >= 1 && i <= 16) begin
                chk({tag, "_u1_ad"}, u1_a_dout, mem_m[i-1]);
                chk({tag, "_u1_bd"}, u1_b_dout, mem_m[i-1]);
            end
        end
        a_re = 1'b0; b_re = 1'b0;
    endtask

    // Counts cycles with ready low while hammering reads and re-pulsing clear_req.
    task automatic count_low(input string tag);
        int   low;
        logic rv;
        low = 0;
        rv  = 1'b0;
        while (u0_ready == 1'b0 && low < 40) begin
            low++;
            clear_req = (low == 5);
            a_re = 1'b1; b_re = 1'b1;
            tick();
            rv = rv | u0_a_rvalid | u0_b_rvalid | u1_a_rvalid | u1_b_rvalid;
        end
        clear_req = 1'b0; a_re = 1'b0; b_re = 1'b0;
        chk({tag, "_low_cycles"}, low, 16);
        chk({tag, "_u1_ready"}, u1_ready, 1'b1);
        chk({tag, "_no_rvalid"}, rv, 1'b0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        tick();
        tick();
        chk("rst_ready0", u0_ready, 1'b0);
        chk("rst_ready1", u1_ready, 1'b0);
        chk("rst_rv", {u0_a_rvalid, u0_b_rvalid, u1_a_rvalid, u1_b_rvalid}, 4'b0);
        chk("rst_dout", {u0_a_dout, u0_b_dout, u1_a_dout, u1_b_dout}, 32'h0);
        rst_n = 1'b1;
        count_low("pwrup");

        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        read_all("zero");

        // Read latency after a write
        wr(3, 8'hA5);
        a_re = 1'b1; a_addr = 4'd3;
        tick();
        a_re = 1'b0;
        chk("lat_u0_v", u0_a_rvalid, 1'b1);
        chk("lat_u0_d", u0_a_dout, 8'hA5);
        chk("lat_u1_v_early", u1_a_rvalid, 1'b0);
        tick();
        chk("lat_u1_v", u1_a_rvalid, 1'b1);
        chk("lat_u1_d", u1_a_dout, 8'hA5);
        chk("lat_u0_v_drop", u0_a_rvalid, 1'b0);
        chk("lat_u0_hold", u0_a_dout, 8'hA5);

        // Read-during-write on port A, port B watching the same address
        wr(5, 8'h11);
        a_we = 1'b1; a_re = 1'b1; a_addr = 4'd5; a_din = 8'h22;
        b_re = 1'b1; b_addr = 4'd5;
        tick();
        a_we = 1'b0; a_re = 1'b0; b_re = 1'b0;
        mem_m[5] = 8'h22;
        chk("rdw_u0_a", u0_a_dout, 8'h11);
        chk("rdw_u0_b", u0_b_dout, 8'h11);
        tick();
        chk("rdw_u1_av", u1_a_rvalid, 1'b1);
        chk("rdw_u1_a", u1_a_dout, 8'h22);
        chk("rdw_u1_b", u1_b_dout, 8'h11);
        chk("rdw_u0_hold", u0_a_dout, 8'h11);

        // Distinct pattern, in-order streaming
        for (int i = 0; i < 16; i++) wr(i, 8'((i * 37 + 5) & 8'hFF));
        read_all("pat");

        // Reset partway through a sweep
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("mid_ready", u0_ready, 1'b0);
        chk("mid_hold", u0_a_dout, mem_m[15]);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dout", {u0_a_dout, u0_b_dout, u1_a_dout, u1_b_dout}, 32'h0);
        chk("mid_rst_ready", {u0_ready, u1_ready}, 2'b0);
        tick();
        rst_n = 1'b1;
        count_low("mid");

        // Fill with FF, clear with a simultaneous write
        for (int i = 0; i < 16; i++) wr(i, 8'hFF);
        clear_req = 1'b1; a_we = 1'b1; a_addr = 4'd2; a_din = 8'h42;
        tick();
        clear_req = 1'b0; a_we = 1'b0;
        count_low("clr");
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        read_all("clr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bram_dp_clr.md
BRAM_DP_CLR -- requirements
Module: bram_dp_clr

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, address bits; depth = 2**ADDR_WIDTH words.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-003 The block SHALL have parameter OUT_REG, default 0, 0 = read latency 1, 1 = extra output register, read latency 2.
REQ-004 The block SHALL have parameter WRITE_FIRST, default 0, port-A same-address read-during-write returns new data when 1, old data when 0.
REQ-005 The block SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-006 The block SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 The block SHALL have port clear_req  in  1  one-cycle request to zero the whole memory.
REQ-008 The block SHALL have port ready  out  1  high when idle and accepting accesses.
REQ-009 The block SHALL have port a_we / a_re  in  1 each  port A write / read enables.
REQ-010 The block SHALL have port a_addr  in  ADDR_WIDTH  port A address.
REQ-011 The block SHALL have port a_din  in  DATA_WIDTH  port A write data.
REQ-012 The block SHALL have port a_dout / a_rvalid  out  DATA_WIDTH / 1  port A read data, valid strobe.
REQ-013 The block SHALL have port b_re, b_addr  in  1, ADDR_WIDTH  port B read-only request.
REQ-014 The block SHALL have port b_dout / b_rvalid  out  DATA_WIDTH / 1  port B read data, valid strobe.

Function
REQ-015 The FSM SHALL have two states: CLEAR (sweep) and IDLE; ready = (state == IDLE).
REQ-016 On reset release the FSM SHALL enter CLEAR with sweep counter 0.
REQ-017 In CLEAR the block SHALL write 0 to address counter each cycle, counter +1, and go to IDLE after writing address 2**ADDR_WIDTH-1; sweep takes exactly 2**ADDR_WIDTH cycles.
REQ-018 In IDLE, clear_req SHALL move the FSM to CLEAR next cycle with counter 0; any port A/B access in that same cycle SHALL still be accepted.
REQ-019 clear_req in CLEAR SHALL be ignored (no restart).
REQ-020 While ready=0, a_we, a_re, b_re SHALL be ignored: no write, no rvalid.
REQ-021 An accepted read on either port SHALL assert that port's rvalid for exactly one cycle, 1+OUT_REG cycles after the request, with dout = addressed word.
REQ-022 Back-to-back reads SHALL be fully pipelined, one result per cycle.
REQ-023 dout SHALL hold its last value when rvalid is low.
REQ-024 Port A simultaneous write+read same address SHALL return a_din if WRITE_FIRST=1, else prior contents.
REQ-025 Port B reading the address port A writes in the same cycle SHALL return prior contents (read-first), independent of WRITE_FIRST.
REQ-026 Address wrap is not applicable; all ADDR_WIDTH-bit addresses SHALL be valid, and the sweep counter SHALL not wrap past the last address.

Reset
REQ-027 rst_n low SHALL asynchronously set ready=0, a_rvalid=b_rvalid=0, a_dout=b_dout=0, counter=0, state=CLEAR, and flush pipeline valids.
REQ-028 Reset SHALL NOT directly alter memory contents; zeroing comes from the sweep.
REQ-029 Reset asserted mid-sweep SHALL restart the sweep from address 0 on release.

Structure
REQ-030 A shared package bram_pkg SHALL hold the FSM state enum typedef (CLEAR, IDLE).
REQ-031 Storage SHALL be a sub-module bram_sdp_core (one write/read port A, one read port B, no reset, synchronous reads) so it infers block RAM; FSM, gating, and output register live in bram_dp_clr.

Verification
REQ-032 ADDR_WIDTH=4, release reset -> ready low for exactly 16 cycles then high; reads of all 16 addresses return 0.
REQ-033 OUT_REG=0: write 0xA5 to addr 3, then a_re addr 3 -> a_rvalid one cycle later with a_dout=0xA5; repeat with OUT_REG=1 -> two cycles later.
REQ-034 addr 5 holds 0x11; same cycle a_we=1, a_re=1, a_din=0x22, b_re addr 5 -> a_dout=0x22 (WRITE_FIRST=1) or 0x11 (0); b_dout=0x11 both cases.
REQ-035 Fill memory with 0xFF, pulse clear_req with simultaneous write 0x42 to addr 2 -> ready low 16 cycles; afterward all reads return 0 including addr 2; a_re during sweep yields no a_rvalid.
REQ-036 Assert rst_n low at sweep cycle 7, release -> outputs 0 immediately, full 16-cycle sweep restarts, ready rises after 16 cycles.
REQ-037 Back-to-back reads of addr 0..15 on both ports -> 16 consecutive rvalid cycles per port, data in order.
